// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RV-style control unit: Moore FSM driving the datapath for lh/sh/beq/R-type/andi.
// Optional macro ILLEGAL_TRAP_EN: unlisted opcodes lock the FSM in TRAP until reset.
module unidade_controle_multiciclo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       pc_write,
  output logic       ir_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t cur, nxt;
  logic [10:0] ctrl_q;

  // Packed as {mem_req, mem_we, i_or_d, pc_src, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op}
  function automatic logic [10:0] moore_ctrl(input state_t s);
    logic [10:0] c;
    c = '0;
    case (s)
      S_FETCH:  c = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
      S_DECODE: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
      S_EXEC_R: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10};
      S_EXEC_I: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11};
      S_ADDR:   c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
      S_MEM_RD: c = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      S_MEM_WR: c = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      S_WB_ALU: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
      S_WB_MEM: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
      S_BRANCH: c = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:               nxt = S_EXEC_R;
          OP_I:               nxt = S_EXEC_I;
          OP_LOAD, OP_STORE:  nxt = S_ADDR;
          OP_BRANCH:          nxt = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:            nxt = S_TRAP;
`else
          default:            nxt = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: nxt = S_WB_ALU;
      S_EXEC_I: nxt = S_WB_ALU;
      S_ADDR:   nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: nxt = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU: nxt = S_FETCH;
      S_WB_MEM: nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   nxt = S_TRAP;
`endif
      default:  nxt = S_FETCH;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  // Moore outputs are registered from the next state so they change together with the state code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= S_FETCH;
      ctrl_q <= moore_ctrl(S_FETCH);
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      cur    <= nxt;
      ctrl_q <= moore_ctrl(nxt);
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= (nxt == S_TRAP);
`endif
    end
  end

  assign {mem_req, mem_we, i_or_d, pc_src, reg_write, mem_to_reg,
          alu_src_a, alu_src_b, alu_op} = ctrl_q;

  // Strobes follow the handshake and the zero flag in the same cycle, suppressed under reset
  assign ir_write = rst_n & (cur == S_FETCH) & mem_ready;
  assign pc_write = rst_n & (((cur == S_FETCH) & mem_ready) | ((cur == S_BRANCH) & zero));
  assign state    = cur;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo: directed scenarios plus random instruction streams.
module tb_unidade_controle_multiciclo;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, pc_write, ir_write, pc_src;
  logic       reg_write, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;
  logic       illegal;

  int checks = 0;
  int passes = 0;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LH = 7'b0000011;
  localparam logic [6:0] OP_SH = 7'b0100011;
  localparam logic [6:0] OP_BQ = 7'b1100011;

  unidade_controle_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .pc_write(pc_write),
    .ir_write(ir_write), .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {mem_req, mem_we, i_or_d, pc_write, ir_write, pc_src, reg_write,
                mem_to_reg, alu_src_a, alu_src_b, alu_op};

  // Expected controls per state, straight from the state table of the control unit
  function automatic logic [12:0] exp_out(input int st, input logic rdy, input logic z);
    case (st)
      0:  return {1'b1, 1'b0, 1'b0, rdy,  rdy,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
      1:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
      2:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10};
      3:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11};
      4:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
      5:  return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      6:  return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      7:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
      8:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
      9:  return {1'b0, 1'b0, 1'b0, z,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
      default: return 13'b0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LH) || (op == OP_SH) || (op == OP_BQ);
  endfunction

  // Executes one instruction; fw/mw are wait cycles in FETCH and in the data handshake
  task automatic run_instr(input logic [6:0] op, input logic zb, input int fw, input int mw,
                           input string tag);
    int seq[$];
    logic rdy[$];
    int exp_len, done_at;
    logic [3:0] prev;
    logic z;
    for (int i = 0; i < fw; i++) begin seq.push_back(0); rdy.push_back(1'b0); end
    seq.push_back(0); rdy.push_back(1'b1);
    seq.push_back(1); rdy.push_back(1'($urandom_range(0, 1)));
    case (op)
      OP_R:  begin seq.push_back(2); rdy.push_back(1'($urandom_range(0, 1)));
                   seq.push_back(7); rdy.push_back(1'($urandom_range(0, 1))); end
      OP_I:  begin seq.push_back(3); rdy.push_back(1'($urandom_range(0, 1)));
                   seq.push_back(7); rdy.push_back(1'($urandom_range(0, 1))); end
      OP_LH: begin seq.push_back(4); rdy.push_back(1'($urandom_range(0, 1)));
                   for (int i = 0; i < mw; i++) begin seq.push_back(5); rdy.push_back(1'b0); end
                   seq.push_back(5); rdy.push_back(1'b1);
                   seq.push_back(8); rdy.push_back(1'($urandom_range(0, 1))); end
      OP_SH: begin seq.push_back(4); rdy.push_back(1'($urandom_range(0, 1)));
                   for (int i = 0; i < mw; i++) begin seq.push_back(6); rdy.push_back(1'b0); end
                   seq.push_back(6); rdy.push_back(1'b1); end
      OP_BQ: begin seq.push_back(9); rdy.push_back(1'($urandom_range(0, 1))); end
      default: ;
    endcase
    case (op)
      OP_BQ:             exp_len = 3 + fw;
      OP_R, OP_I, OP_SH: exp_len = 4 + fw + ((op == OP_SH) ? mw : 0);
      OP_LH:             exp_len = 5 + fw + mw;
      default:           exp_len = 2 + fw;
    endcase
    done_at = -1;
    prev = 4'hF;
    for (int i = 0; i <= seq.size(); i++) begin
      @(negedge clk);
      opcode = op;
      if (i < seq.size()) begin
        mem_ready = rdy[i];
        z = (seq[i] == 9) ? zb : 1'($urandom_range(0, 1));
        zero = z;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (done_at < 0 && i > 0 && state == 4'd0 && prev != 4'd0) done_at = i;
      prev = state;
      if (i == seq.size()) break;
      checks++;
      if (state !== 4'(seq[i]))
        $display("[TB] FAIL %s state cyc %0d: got %0d want %0d", tag, i, state, seq[i]);
      else passes++;
      checks++;
      if (obs !== exp_out(seq[i], rdy[i], z))
        $display("[TB] FAIL %s ctrl cyc %0d st %0d: got %b want %b", tag, i, seq[i], obs,
                 exp_out(seq[i], rdy[i], z));
      else passes++;
      checks++;
      if (illegal !== 1'b0)
        $display("[TB] FAIL %s illegal cyc %0d: got %b want 0", tag, i, illegal);
      else passes++;
    end
    checks++;
    if (done_at != exp_len)
      $display("[TB] FAIL %s cycles: got %0d want %0d", tag, done_at, exp_len);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = OP_R;
    #2;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0)
      $display("[TB] FAIL reset_state: got %0d/%b want 0/0", state, illegal);
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_out(0, 1'b0, 1'b0))
      $display("[TB] FAIL reset_ctrl: got %b want %b", obs, exp_out(0, 1'b0, 1'b0));
    else passes++;
    checks++;
    if (state !== 4'd0)
      $display("[TB] FAIL reset_hold: got %0d want 0", state);
    else passes++;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    run_instr(OP_R, 1'b0, 0, 0, "rtype");
  endtask

  task automatic test_load_wait();
    run_instr(OP_LH, 1'b0, 0, 2, "load_wait");
  endtask

  task automatic test_branch();
    run_instr(OP_BQ, 1'b1, 0, 0, "beq_taken");
    run_instr(OP_BQ, 1'b0, 0, 0, "beq_not_taken");
  endtask

  task automatic test_store();
    run_instr(OP_SH, 1'b0, 1, 1, "store");
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [5];
    logic [6:0] op;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LH; ops[3] = OP_SH; ops[4] = OP_BQ;
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 4)];
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(0, 5) == 0) begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end
`endif
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                "random");
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); opcode = OP_LH; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd5)
      $display("[TB] FAIL midrd_pre: got %0d want 5", state);
    else passes++;
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0)
      $display("[TB] FAIL midrd_async: got %0d/%b want 0/0", state, illegal);
    else passes++;
    checks++;
    if (obs !== exp_out(0, 1'b0, 1'b0))
      $display("[TB] FAIL midrd_ctrl: got %b want %b", obs, exp_out(0, 1'b0, 1'b0));
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (pc_write !== 1'b0 || ir_write !== 1'b0 || state !== 4'd0)
      $display("[TB] FAIL midrd_edge: got pcw %b irw %b st %0d want 0 0 0", pc_write, ir_write, state);
    else passes++;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || mem_req !== 1'b1 || i_or_d !== 1'b0)
      $display("[TB] FAIL midrd_refetch: got st %0d req %b iod %b want 0 1 0", state, mem_req, i_or_d);
    else passes++;
    run_instr(OP_R, 1'b0, 0, 0, "after_reset");
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    @(negedge clk); opcode = 7'b1111111; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (state !== 4'd10 || illegal !== 1'b1 || obs !== 13'b0)
        $display("[TB] FAIL trap cyc %0d: got st %0d ill %b ctrl %b want 10 1 0", i, state, illegal, obs);
      else passes++;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0)
      $display("[TB] FAIL trap_exit: got %0d/%b want 0/0", state, illegal);
    else passes++;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    run_instr(OP_I, 1'b0, 0, 0, "after_trap");
`else
    run_instr(7'b1111111, 1'b0, 0, 0, "illegal_nop");
`endif
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 7'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_store();
    test_back_to_back();
    test_reset_mid_read();
    test_illegal();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
